fixed_128_div: RTL and testbench

//  Iterative signed fixed-point divider, the inverse of the regressor's 64x64 multiply path.

---
 rtl/fixed_128_div_pkg.sv | 34 +++
 rtl/fixed_128_div_if.sv | 33 +++
 rtl/fixed_128_div_udiv_iter.sv | 67 ++++++
 rtl/fixed_128_div.sv | 125 ++++++++++++
 tb/tb_fixed_128_div.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_128_div_pkg.sv
// Shared constants, state type and helpers for the 128/64 fixed-point divider.
//   FRACT_BITS : fractional bits of every Q format (Q120.8 / Q56.8)
//   DIVD_W     : dividend width, DIVS_W : divisor and quotient width
//   NUM_W      : numerator width, also the number of quotient iterations
//   Q_MAX/Q_MIN: saturation values of the signed quotient
package fixed_128_div_pkg;

    localparam int FRACT_BITS = 8;
    localparam int DIVD_W     = 128;
    localparam int DIVS_W     = 64;
    localparam int NUM_W      = DIVD_W + FRACT_BITS;
    localparam int CNT_W      = $clog2(NUM_W);

    localparam logic [DIVS_W-1:0] Q_MAX = {1'b0, {(DIVS_W-1){1'b1}}};
    localparam logic [DIVS_W-1:0] Q_MIN = {1'b1, {(DIVS_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Magnitude of a two's-complement dividend. -2^127 maps to 2^127,
    // which is representable because the result is read as unsigned.
    function automatic logic [DIVD_W-1:0] abs_divd(input logic [DIVD_W-1:0] v);
        return v[DIVD_W-1] ? (~v + DIVD_W'(1)) : v;
    endfunction

    function automatic logic [DIVS_W-1:0] abs_divs(input logic [DIVS_W-1:0] v);
        return v[DIVS_W-1] ? (~v + DIVS_W'(1)) : v;
    endfunction

endpackage

// File: rtl/fixed_128_div_if.sv
// Operand/result handshake bundle of the divider.
// Both sides use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high; valid, once raised, holds its payload stable
// until that edge, and ready may depend on nothing but the receiver's state.
//   in_valid/in_ready/dividend_in/divisor_in : operand channel
//   out_valid/out_ready/q_out/overflow/div_by_zero : result channel
//   busy : divider is not idle
// master = operand producer / result consumer, slave = the divider.
interface fixed_128_div_if;
    import fixed_128_div_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DIVD_W-1:0] dividend_in;
    logic [DIVS_W-1:0] divisor_in;
    logic              out_valid;
    logic              out_ready;
    logic [DIVS_W-1:0] q_out;
    logic              overflow;
    logic              div_by_zero;
    logic              busy;

    modport master (
        output in_valid, dividend_in, divisor_in, out_ready,
        input  in_ready, out_valid, q_out, overflow, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend_in, divisor_in, out_ready,
        output in_ready, out_valid, q_out, overflow, div_by_zero, busy
    );

endinterface

// File: rtl/fixed_128_div_udiv_iter.sv
// Unsigned shift-subtract division core, one quotient bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands (single-cycle pulse)
//   divd_mag   : unsigned dividend magnitude; scaled by 2^FRACT_BITS internally
//   divs_mag   : unsigned divisor magnitude, must be non-zero
//   done       : high during the cycle that computes the last quotient bit
//   q_mag      : unsigned NUM_W-bit quotient, valid the cycle after done
module fixed_128_div_udiv_iter
    import fixed_128_div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIVD_W-1:0] divd_mag,
    input  logic [DIVS_W-1:0] divs_mag,
    output logic              done,
    output logic [NUM_W-1:0]  q_mag
);

    // num_q starts as the numerator and is shifted left each cycle; the
    // freed LSB receives the new quotient bit, so after NUM_W cycles it
    // holds the quotient.
    logic [NUM_W-1:0]  num_q;
    logic [DIVS_W-1:0] rem_q;
    logic [DIVS_W-1:0] divs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              running_q;

    logic [DIVS_W:0]   rem_sh;
    logic [DIVS_W:0]   rem_diff;
    logic              ge;

    // rem < divisor keeps rem_sh below 2*divisor, so the difference lies in
    // (-divisor, divisor) and its top bit is a clean borrow flag.
    always_comb begin
        rem_sh   = {rem_q, num_q[NUM_W-1]};
        rem_diff = rem_sh - {1'b0, divs_q};
        ge       = ~rem_diff[DIVS_W];
    end

    assign done  = running_q && (cnt_q == CNT_W'(NUM_W - 1));
    assign q_mag = num_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q     <= '0;
            rem_q     <= '0;
            divs_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            num_q     <= {divd_mag, {FRACT_BITS{1'b0}}};
            rem_q     <= '0;
            divs_q    <= divs_mag;
            cnt_q     <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            num_q <= {num_q[NUM_W-2:0], ge};
            rem_q <= ge ? rem_diff[DIVS_W-1:0] : rem_sh[DIVS_W-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fixed_128_div.sv
// Signed fixed-point divider: Q120.8 dividend / Q56.8 divisor -> Q56.8 quotient.
// Truncates toward zero, saturates to Q_MAX/Q_MIN with an overflow flag, and
// reports divide-by-zero. One operation in flight.
//   clk, rst_n : clock, async active-low reset (aborts any operation)
//   bus        : operand/result handshake (slave side), see fixed_128_div_if
//   state_dbg  : current controller state
module fixed_128_div
    import fixed_128_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    fixed_128_div_if.slave bus,
    output div_state_t state_dbg
);

    div_state_t state_q, state_d;

    logic              accept;
    logic              divs_zero;
    logic              core_start;
    logic              core_done;
    logic [NUM_W-1:0]  core_q;

    logic              neg_q;
    logic              dvd_neg_q;
    logic              dz_q;

    logic              out_valid_q;
    logic [DIVS_W-1:0] q_out_q;
    logic              ovf_q;
    logic              dz_out_q;

    logic [DIVS_W-1:0] fix_q;
    logic              fix_ovf;
    logic              fix_dz;

    assign accept     = bus.in_valid && (state_q == IDLE);
    assign divs_zero  = (bus.divisor_in == '0);
    assign core_start = accept && !divs_zero;

    fixed_128_div_udiv_iter u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (core_start),
        .divd_mag (abs_divd(bus.dividend_in)),
        .divs_mag (abs_divs(bus.divisor_in)),
        .done     (core_done),
        .q_mag    (core_q)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)        state_d = divs_zero ? FIX : CALC;
            CALC: if (core_done)     state_d = FIX;
            FIX:                     state_d = DONE;
            DONE: if (bus.out_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Sign and saturation applied to the unsigned quotient. A negative
    // result may reach 2^63 exactly (Q_MIN) without overflowing; negating a
    // zero magnitude yields +0, so there is no negative zero.
    always_comb begin
        fix_q   = '0;
        fix_ovf = 1'b0;
        fix_dz  = 1'b0;
        if (dz_q) begin
            fix_dz = 1'b1;
            fix_q  = dvd_neg_q ? Q_MIN : Q_MAX;
        end else if (neg_q) begin
            if (core_q > NUM_W'(Q_MIN)) begin
                fix_q   = Q_MIN;
                fix_ovf = 1'b1;
            end else begin
                fix_q = ~core_q[DIVS_W-1:0] + DIVS_W'(1);
            end
        end else begin
            if (core_q > NUM_W'(Q_MAX)) begin
                fix_q   = Q_MAX;
                fix_ovf = 1'b1;
            end else begin
                fix_q = core_q[DIVS_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            neg_q       <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            ovf_q       <= 1'b0;
            dz_out_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                neg_q     <= bus.dividend_in[DIVD_W-1] ^ bus.divisor_in[DIVS_W-1];
                dvd_neg_q <= bus.dividend_in[DIVD_W-1];
                dz_q      <= divs_zero;
            end
            if (state_q == FIX) begin
                out_valid_q <= 1'b1;
                q_out_q     <= fix_q;
                ovf_q       <= fix_ovf;
                dz_out_q    <= fix_dz;
            end else if (state_q == DONE && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.q_out       = q_out_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dz_out_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_fixed_128_div.sv
// Bench for fixed_128_div: directed spec cases, randomized operands against
// an arithmetic reference model, backpressure and mid-operation reset.
module tb_fixed_128_div;
    import fixed_128_div_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fixed_128_div_if bus();
    div_state_t state_dbg;

    fixed_128_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    int n_checks;
    int n_pass;
    logic [63:0] exp_q[$];

    localparam logic [63:0] QMAX_C = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] QMIN_C = 64'h8000_0000_0000_0000;

    // ---------------- reference model ----------------
    // Exact magnitude division of the scaled numerator, then sign and
    // saturation by numeric range.
    function automatic void model(input logic signed [127:0] a, input logic signed [63:0] b,
                                  output logic [63:0] q, output logic ov, output logic dz);
        logic [127:0] ua;
        logic [63:0]  ub;
        logic [135:0] num;
        logic [135:0] mq;
        logic         neg;
        ov = 1'b0;
        dz = 1'b0;
        q  = '0;
        if (b == 0) begin
            dz = 1'b1;
            q  = (a < 0) ? QMIN_C : QMAX_C;
        end else begin
            ua  = (a < 0) ? 128'(-a) : 128'(a);
            ub  = (b < 0) ? 64'(-b) : 64'(b);
            num = {ua, 8'h00};
            mq  = num / {72'h0, ub};
            neg = (a < 0) != (b < 0);
            if (!neg) begin
                if (mq > 136'h7FFF_FFFF_FFFF_FFFF) begin q = QMAX_C; ov = 1'b1; end
                else q = mq[63:0];
            end else begin
                if (mq > 136'h8000_0000_0000_0000) begin q = QMIN_C; ov = 1'b1; end
                else q = 64'(64'd0 - mq[63:0]);
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [127:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.dividend_in = a;
        bus.divisor_in  = b;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.dividend_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.divisor_in  = {$urandom(), $urandom()};
    endtask

    // Counts rising edges after the acceptance edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 300);
    endtask

    task automatic run_op(input logic [127:0] a, input logic [63:0] b, input logic [63:0] eq,
                          input logic eov, input logic edz, input int elat, input string tag);
        int lat;
        logic [63:0] want;
        exp_q.push_back(eq);
        send(a, b);
        wait_result(lat);
        want = exp_q.pop_front();
        n_checks++;
        if (lat !== elat) $display("FAIL %s latency: got %0d want %0d", tag, lat, elat);
        else n_pass++;
        n_checks++;
        if (bus.q_out !== want) $display("FAIL %s q_out: got %h want %h (a=%h b=%h)", tag, bus.q_out, want, a, b);
        else n_pass++;
        n_checks++;
        if (bus.overflow !== eov) $display("FAIL %s overflow: got %b want %b", tag, bus.overflow, eov);
        else n_pass++;
        n_checks++;
        if (bus.div_by_zero !== edz) $display("FAIL %s div_by_zero: got %b want %b", tag, bus.div_by_zero, edz);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL %s drain: out_valid=%b in_ready=%b want 0/1", tag, bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.q_out !== 64'h0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0 || state_dbg !== IDLE)
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b q=%h ov=%b dz=%b want 1/0/0/0/0/0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.q_out, bus.overflow, bus.div_by_zero);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(128'h600, 64'h200, 64'h300, 1'b0, 1'b0, 137, "six_by_two");
        run_op(-128'sd1920, 64'h200, 64'hFFFF_FFFF_FFFF_FC40, 1'b0, 1'b0, 137, "neg_7p5");
        run_op(128'h100, 64'h300, 64'h55, 1'b0, 1'b0, 137, "one_third");
        run_op(-128'sd256, 64'h300, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0, 1'b0, 137, "neg_one_third");
        run_op(128'h100, 64'h0, QMAX_C, 1'b0, 1'b1, 1, "dz_pos");
        run_op(-128'sd256, 64'h0, QMIN_C, 1'b0, 1'b1, 1, "dz_neg");
        run_op(128'd1 << 100, 64'h1, QMAX_C, 1'b1, 1'b0, 137, "ovf_pos");
        run_op(128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 64'h100, QMIN_C, 1'b0, 1'b0, 137, "min_exact");
        run_op(128'h7FFF_FFFF_FFFF_FFFF, 64'h100, QMAX_C, 1'b0, 1'b0, 137, "max_exact");
        run_op(128'h8000_0000_0000_0000, 64'h100, QMAX_C, 1'b1, 1'b0, 137, "pos_just_over");
        run_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 64'h100, QMIN_C, 1'b1, 1'b0, 137, "most_neg");
        run_op(128'h0, -64'sd512, 64'h0, 1'b0, 1'b0, 137, "zero_neg_divisor");
    endtask

    task automatic test_random();
        logic [127:0] a;
        logic [63:0]  b;
        logic [63:0]  eq;
        logic         eov;
        logic         edz;
        for (int i = 0; i < 24; i++) begin
            a = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 127);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = {$urandom(), $urandom()} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) b = -b;
            if ($urandom_range(0, 7) == 0) b = '0;
            model(a, b, eq, eov, edz);
            run_op(a, b, eq, eov, edz, edz ? 1 : 137, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        send(128'h600, 64'h200);
        bus.out_ready = 1'b0;
        wait_result(lat);
        n_checks++;
        if (lat !== 137 || bus.q_out !== 64'h300) $display("FAIL bp_result: lat=%0d q=%h want 137/300", lat, bus.q_out);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid    = 1'b1;
            bus.dividend_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            bus.divisor_in  = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.q_out !== 64'h300 || bus.overflow !== 1'b0 ||
                bus.div_by_zero !== 1'b0 || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold%0d: out_valid=%b q=%h ov=%b dz=%b in_ready=%b want 1/300/0/0/0",
                         i, bus.out_valid, bus.q_out, bus.overflow, bus.div_by_zero, bus.in_ready);
            else n_pass++;
        end
        @(negedge clk);
        bus.out_ready   = 1'b1;
        bus.dividend_in = 128'h100;
        bus.divisor_in  = 64'h300;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) $display("FAIL bp_next_accept: busy=%b want 1", bus.busy);
        else n_pass++;
        wait_result(lat);
        n_checks++;
        if (lat !== 137 || bus.q_out !== 64'h55) $display("FAIL bp_next_result: lat=%0d q=%h want 137/55", lat, bus.q_out);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        send(128'h600, 64'h200);
        repeat (50) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1)
            $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(128'h600, 64'h200, 64'h300, 1'b0, 1'b0, 137, "after_reset");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
